// File: rtl/countdown_pkg.sv
// Package shared by the countdown engine files.
//   state_t        : top-level FSM states.
//   BCD_MAX_DIGIT  : largest legal BCD digit value.
//   is_bcd_digit() : true when a nibble is a legal BCD digit (0..9).
package countdown_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  function automatic logic is_bcd_digit(input logic [3:0] digit);
    return (digit <= BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/countdown_if.sv
// Keypad/tick event bus and status outputs of the countdown engine.
//   master : event source / status consumer (keypad decoder, display scanner)
//   slave  : countdown_core
// Events (tick, keydown_*) are one-cycle pulses; num is valid with keydown_num.
// Status outputs: display_en, input_bcd, remaining_bcd, running, done, alarm.
interface countdown_if #(
  parameter int DIGITS = 2
);
  logic                  tick;
  logic                  keydown_num;
  logic                  keydown_start;
  logic                  keydown_confirm;
  logic                  keydown_clear;
  logic [3:0]            num;
  logic                  display_en;
  logic [4*DIGITS-1:0]   input_bcd;
  logic [4*DIGITS-1:0]   remaining_bcd;
  logic                  running;
  logic                  done;
  logic                  alarm;

  modport master (
    output tick, keydown_num, keydown_start, keydown_confirm, keydown_clear, num,
    input  display_en, input_bcd, remaining_bcd, running, done, alarm
  );

  modport slave (
    input  tick, keydown_num, keydown_start, keydown_confirm, keydown_clear, num,
    output display_en, input_bcd, remaining_bcd, running, done, alarm
  );
endinterface

// File: rtl/countdown_bcd_decrementer.sv
// Combinational multi-digit BCD decrement.
//   value     : DIGITS-digit BCD input, digit 0 in [3:0]
//   value_dec : value - 1 in BCD (each digit wraps 0 -> 9 with a borrow)
//   is_one    : value equals 1
module bcd_decrementer
  import countdown_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic [4*DIGITS-1:0] value,
  output logic [4*DIGITS-1:0] value_dec,
  output logic                is_one
);

  logic       borrow_s;
  logic [3:0] digit_s;

  // Ripple a borrow from digit 0 upward; a zero digit under borrow becomes 9.
  always_comb begin
    borrow_s  = 1'b1;
    digit_s   = 4'd0;
    value_dec = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit_s = value[4*i +: 4];
      if (borrow_s) begin
        if (digit_s == 4'd0) begin
          value_dec[4*i +: 4] = BCD_MAX_DIGIT;
          borrow_s            = 1'b1;
        end else begin
          value_dec[4*i +: 4] = digit_s - 4'd1;
          borrow_s            = 1'b0;
        end
      end else begin
        value_dec[4*i +: 4] = digit_s;
        borrow_s            = 1'b0;
      end
    end
  end

  assign is_one = (value == (4*DIGITS)'(1));

endmodule

// File: rtl/countdown_core.sv
// Parametrised BCD countdown engine.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : countdown_if.slave -- keypad events and 1 Hz tick in,
//                registered status (display_en, input_bcd, remaining_bcd,
//                running, done, alarm) out
// Parameters: DIGITS (1..8), AUTO_RELOAD (0/1), ALARM_TICKS (>=1).
module countdown_core
  import countdown_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int AUTO_RELOAD = 0,
  parameter int ALARM_TICKS = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  countdown_if.slave     bus
);

  localparam int              W          = 4 * DIGITS;
  localparam int              ACW        = $clog2(ALARM_TICKS + 1);
  localparam logic [ACW-1:0]  ALARM_LAST = ACW'(ALARM_TICKS - 1);

  state_t          state_r;
  logic [W-1:0]    input_r;
  logic [W-1:0]    remaining_r;
  logic            display_en_r;
  logic            running_r;
  logic            done_r;
  logic            alarm_r;
  logic [ACW-1:0]  alarm_cnt_r;
  logic            reload_pending_r;

  logic            key_any_s;
  logic [W-1:0]    shifted_s;
  logic [W-1:0]    remaining_dec_s;
  logic            remaining_is_one_s;

  // Any key pulse clears the alarm and swallows a same-cycle tick.
  assign key_any_s = bus.keydown_num | bus.keydown_start |
                     bus.keydown_confirm | bus.keydown_clear;

  // Entry shift: drop the MSD, new digit enters at digit 0.
  if (DIGITS == 1) begin : g_shift_one
    assign shifted_s = bus.num;
  end else begin : g_shift_multi
    assign shifted_s = {input_r[W-5:0], bus.num};
  end

  bcd_decrementer #(.DIGITS(DIGITS)) u_dec (
    .value     (remaining_r),
    .value_dec (remaining_dec_s),
    .is_one    (remaining_is_one_s)
  );

  // Control FSM, entry register, remaining counter and alarm timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      input_r          <= '0;
      remaining_r      <= '0;
      display_en_r     <= 1'b0;
      running_r        <= 1'b0;
      done_r           <= 1'b0;
      alarm_r          <= 1'b0;
      alarm_cnt_r      <= '0;
      reload_pending_r <= 1'b0;
    end else begin
      done_r <= 1'b0;

      // Alarm timer; the zero-reaching tick below may re-arm it.
      if (key_any_s) begin
        alarm_r     <= 1'b0;
        alarm_cnt_r <= '0;
      end else if (bus.tick && alarm_r) begin
        if (alarm_cnt_r == ALARM_LAST) begin
          alarm_r     <= 1'b0;
          alarm_cnt_r <= '0;
        end else begin
          alarm_cnt_r <= alarm_cnt_r + ACW'(1);
        end
      end else begin
        alarm_cnt_r <= alarm_cnt_r;
      end

      // Auto-reload lands one cycle after zero; a key this cycle may override it.
      if (reload_pending_r) begin
        remaining_r      <= input_r;
        reload_pending_r <= 1'b0;
      end else begin
        reload_pending_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (bus.keydown_start) begin
            state_r      <= ENTRY;
            input_r      <= '0;
            display_en_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end

        ENTRY: begin
          if (bus.keydown_clear) begin
            input_r <= '0;
          end else if (bus.keydown_confirm) begin
            if (input_r != '0) begin
              remaining_r <= input_r;
              state_r     <= RUN;
              running_r   <= 1'b1;
            end else begin
              state_r <= ENTRY;
            end
          end else if (bus.keydown_start) begin
            state_r <= ENTRY;
          end else if (bus.keydown_num && is_bcd_digit(bus.num)) begin
            input_r <= shifted_s;
          end else begin
            state_r <= ENTRY;
          end
        end

        RUN: begin
          if (bus.keydown_clear) begin
            state_r          <= ENTRY;
            input_r          <= '0;
            remaining_r      <= '0;
            running_r        <= 1'b0;
            reload_pending_r <= 1'b0;
          end else if (bus.keydown_confirm) begin
            state_r   <= PAUSE;
            running_r <= 1'b0;
          end else if (bus.keydown_start) begin
            remaining_r <= input_r;
          end else if (bus.keydown_num) begin
            state_r <= RUN;
          end else if (bus.tick && (remaining_r != '0)) begin
            if (remaining_is_one_s) begin
              remaining_r <= '0;
              done_r      <= 1'b1;
              alarm_r     <= 1'b1;
              alarm_cnt_r <= '0;
              if (AUTO_RELOAD != 0) begin
                reload_pending_r <= 1'b1;
              end else begin
                state_r   <= DONE;
                running_r <= 1'b0;
              end
            end else begin
              remaining_r <= remaining_dec_s;
            end
          end else begin
            state_r <= RUN;
          end
        end

        PAUSE: begin
          if (bus.keydown_clear) begin
            state_r     <= ENTRY;
            input_r     <= '0;
            remaining_r <= '0;
          end else if (bus.keydown_confirm) begin
            state_r   <= RUN;
            running_r <= 1'b1;
          end else if (bus.keydown_start) begin
            state_r     <= RUN;
            running_r   <= 1'b1;
            remaining_r <= input_r;
          end else begin
            state_r <= PAUSE;
          end
        end

        DONE: begin
          if (bus.keydown_clear) begin
            state_r <= ENTRY;
            input_r <= '0;
          end else if (bus.keydown_confirm) begin
            state_r     <= RUN;
            running_r   <= 1'b1;
            remaining_r <= input_r;
          end else if (bus.keydown_start) begin
            state_r      <= IDLE;
            input_r      <= '0;
            remaining_r  <= '0;
            display_en_r <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end

        default: begin
          state_r          <= IDLE;
          input_r          <= '0;
          remaining_r      <= '0;
          display_en_r     <= 1'b0;
          running_r        <= 1'b0;
          alarm_r          <= 1'b0;
          reload_pending_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.display_en    = display_en_r;
  assign bus.input_bcd     = input_r;
  assign bus.remaining_bcd = remaining_r;
  assign bus.running       = running_r;
  assign bus.done          = done_r;
  assign bus.alarm         = alarm_r;

endmodule

// File: tb/tb_countdown_core.sv
// Directed bench for countdown_core: one default instance (AUTO_RELOAD=0)
// and one AUTO_RELOAD=1 instance, both driven with identical stimulus.
module tb_countdown_core;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  countdown_if #(.DIGITS(2)) bus ();
  countdown_if #(.DIGITS(2)) bus_ar ();

  countdown_core #(.DIGITS(2), .AUTO_RELOAD(0), .ALARM_TICKS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  countdown_core #(.DIGITS(2), .AUTO_RELOAD(1), .ALARM_TICKS(3)) dut_ar (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_ar.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of events (from a falling edge), then idle the inputs.
  task automatic cyc(input logic t, input logic st, input logic cf, input logic cl,
                     input logic kn, input logic [3:0] n);
    bus.tick = t;    bus.keydown_start = st;    bus.keydown_confirm = cf;
    bus.keydown_clear = cl;    bus.keydown_num = kn;    bus.num = n;
    bus_ar.tick = t; bus_ar.keydown_start = st; bus_ar.keydown_confirm = cf;
    bus_ar.keydown_clear = cl; bus_ar.keydown_num = kn; bus_ar.num = n;
    @(negedge clk);
    bus.tick = 1'b0;    bus.keydown_start = 1'b0;    bus.keydown_confirm = 1'b0;
    bus.keydown_clear = 1'b0;    bus.keydown_num = 1'b0;    bus.num = 4'd0;
    bus_ar.tick = 1'b0; bus_ar.keydown_start = 1'b0; bus_ar.keydown_confirm = 1'b0;
    bus_ar.keydown_clear = 1'b0; bus_ar.keydown_num = 1'b0; bus_ar.num = 4'd0;
  endtask

  task automatic key_num(input logic [3:0] n);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, n);
  endtask

  task automatic tick1();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic idle1();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle1();
    idle1();
    rst_n = 1'b1;
    idle1();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.display_en, bus.input_bcd, bus.remaining_bcd, bus.running, bus.done, bus.alarm} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {bus.display_en, bus.input_bcd, bus.remaining_bcd, bus.running, bus.done, bus.alarm});
    end
    checks++;
    if ({bus_ar.display_en, bus_ar.input_bcd, bus_ar.remaining_bcd, bus_ar.running, bus_ar.done, bus_ar.alarm} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs_ar: got %h expected 0", {bus_ar.display_en, bus_ar.input_bcd, bus_ar.remaining_bcd, bus_ar.running, bus_ar.done, bus_ar.alarm});
    end
  endtask

  task automatic test_entry_confirm();
    do_reset();
    key_num(4'd7);  // ignored in IDLE
    checks++;
    if (bus.display_en !== 1'b0 || bus.input_bcd !== 8'h00) begin
      errors++;
      $display("FAIL idle_ignore: got en=%b in=%h expected en=0 in=00", bus.display_en, bus.input_bcd);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checks++;
    if (bus.display_en !== 1'b1 || bus.input_bcd !== 8'h00 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL start_entry: got en=%b in=%h run=%b expected en=1 in=00 run=0", bus.display_en, bus.input_bcd, bus.running);
    end
    key_num(4'd4);
    key_num(4'd2);
    checks++;
    if (bus.input_bcd !== 8'h42) begin
      errors++;
      $display("FAIL entry_42: got %h expected 42", bus.input_bcd);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checks++;
    if (bus.remaining_bcd !== 8'h42 || bus.running !== 1'b1 || bus.display_en !== 1'b1 || bus.input_bcd !== 8'h42) begin
      errors++;
      $display("FAIL confirm_run: got rem=%h run=%b en=%b in=%h expected rem=42 run=1 en=1 in=42", bus.remaining_bcd, bus.running, bus.display_en, bus.input_bcd);
    end
  endtask

  task automatic test_countdown_alarm();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    key_num(4'd1);
    key_num(4'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick1();
    checks++;
    if (bus.remaining_bcd !== 8'h09) begin
      errors++;
      $display("FAIL borrow_10_09: got %h expected 09", bus.remaining_bcd);
    end
    for (int i = 0; i < 8; i++) tick1();
    checks++;
    if (bus.remaining_bcd !== 8'h01 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL count_to_01: got rem=%h done=%b expected rem=01 done=0", bus.remaining_bcd, bus.done);
    end
    tick1();
    checks++;
    if (bus.remaining_bcd !== 8'h00 || bus.done !== 1'b1 || bus.alarm !== 1'b1 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL reach_zero: got rem=%h done=%b alarm=%b run=%b expected 00 1 1 0", bus.remaining_bcd, bus.done, bus.alarm, bus.running);
    end
    idle1();
    checks++;
    if (bus.done !== 1'b0 || bus.alarm !== 1'b1) begin
      errors++;
      $display("FAIL done_one_cycle: got done=%b alarm=%b expected done=0 alarm=1", bus.done, bus.alarm);
    end
    tick1();
    tick1();
    checks++;
    if (bus.alarm !== 1'b1 || bus.remaining_bcd !== 8'h00) begin
      errors++;
      $display("FAIL alarm_after_2: got alarm=%b rem=%h expected alarm=1 rem=00", bus.alarm, bus.remaining_bcd);
    end
    tick1();
    checks++;
    if (bus.alarm !== 1'b0) begin
      errors++;
      $display("FAIL alarm_after_3: got %b expected 0", bus.alarm);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);  // start in DONE -> IDLE
    checks++;
    if ({bus.display_en, bus.input_bcd, bus.remaining_bcd, bus.running} !== 18'd0) begin
      errors++;
      $display("FAIL done_start_idle: got %h expected 0", {bus.display_en, bus.input_bcd, bus.remaining_bcd, bus.running});
    end
  endtask

  task automatic test_entry_edges();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    key_num(4'd1);
    key_num(4'd2);
    key_num(4'd3);
    checks++;
    if (bus.input_bcd !== 8'h23) begin
      errors++;
      $display("FAIL entry_shift_23: got %h expected 23", bus.input_bcd);
    end
    key_num(4'd12);
    checks++;
    if (bus.input_bcd !== 8'h23) begin
      errors++;
      $display("FAIL entry_non_bcd: got %h expected 23", bus.input_bcd);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checks++;
    if (bus.input_bcd !== 8'h00) begin
      errors++;
      $display("FAIL entry_clear: got %h expected 00", bus.input_bcd);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    key_num(4'd5);
    checks++;
    if (bus.running !== 1'b0 || bus.remaining_bcd !== 8'h00 || bus.input_bcd !== 8'h05) begin
      errors++;
      $display("FAIL confirm_zero_stays: got run=%b rem=%h in=%h expected run=0 rem=00 in=05", bus.running, bus.remaining_bcd, bus.input_bcd);
    end
  endtask

  task automatic test_pause_resume();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    key_num(4'd3);
    key_num(4'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);  // confirm beats start -> PAUSE
    checks++;
    if (bus.running !== 1'b0 || bus.remaining_bcd !== 8'h30) begin
      errors++;
      $display("FAIL pause_enter: got run=%b rem=%h expected run=0 rem=30", bus.running, bus.remaining_bcd);
    end
    for (int i = 0; i < 5; i++) tick1();
    checks++;
    if (bus.remaining_bcd !== 8'h30 || bus.display_en !== 1'b1) begin
      errors++;
      $display("FAIL pause_hold: got rem=%h en=%b expected rem=30 en=1", bus.remaining_bcd, bus.display_en);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick1();
    checks++;
    if (bus.running !== 1'b1 || bus.remaining_bcd !== 8'h29) begin
      errors++;
      $display("FAIL resume_dec: got run=%b rem=%h expected run=1 rem=29", bus.running, bus.remaining_bcd);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);  // restart while running
    checks++;
    if (bus.running !== 1'b1 || bus.remaining_bcd !== 8'h30) begin
      errors++;
      $display("FAIL run_restart: got run=%b rem=%h expected run=1 rem=30", bus.running, bus.remaining_bcd);
    end
  endtask

  task automatic test_auto_reload();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    key_num(4'd3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick1();
    tick1();
    checks++;
    if (bus_ar.remaining_bcd !== 8'h01) begin
      errors++;
      $display("FAIL ar_count: got %h expected 01", bus_ar.remaining_bcd);
    end
    tick1();
    checks++;
    if (bus_ar.remaining_bcd !== 8'h00 || bus_ar.done !== 1'b1 || bus_ar.running !== 1'b1) begin
      errors++;
      $display("FAIL ar_zero: got rem=%h done=%b run=%b expected 00 1 1", bus_ar.remaining_bcd, bus_ar.done, bus_ar.running);
    end
    idle1();
    checks++;
    if (bus_ar.remaining_bcd !== 8'h03 || bus_ar.done !== 1'b0 || bus_ar.running !== 1'b1 || bus_ar.alarm !== 1'b1) begin
      errors++;
      $display("FAIL ar_reload: got rem=%h done=%b run=%b alarm=%b expected 03 0 1 1", bus_ar.remaining_bcd, bus_ar.done, bus_ar.running, bus_ar.alarm);
    end
    tick1();
    checks++;
    if (bus_ar.remaining_bcd !== 8'h02) begin
      errors++;
      $display("FAIL ar_continue: got %h expected 02", bus_ar.remaining_bcd);
    end
  endtask

  task automatic test_clear_tick_and_reset();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    key_num(4'd4);
    key_num(4'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick1();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checks++;
    if (bus.remaining_bcd !== 8'h00 || bus.input_bcd !== 8'h00 || bus.running !== 1'b0 || bus.display_en !== 1'b1) begin
      errors++;
      $display("FAIL clear_beats_tick: got rem=%h in=%h run=%b en=%b expected 00 00 0 1", bus.remaining_bcd, bus.input_bcd, bus.running, bus.display_en);
    end
    key_num(4'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    bus.tick = 1'b1;
    bus_ar.tick = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.display_en, bus.input_bcd, bus.remaining_bcd, bus.running, bus.done, bus.alarm} !== 21'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", {bus.display_en, bus.input_bcd, bus.remaining_bcd, bus.running, bus.done, bus.alarm});
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.remaining_bcd !== 8'h00) begin
      errors++;
      $display("FAIL reset_no_done: got done=%b rem=%h expected 0 00", bus.done, bus.remaining_bcd);
    end
    bus.tick = 1'b0;
    bus_ar.tick = 1'b0;
    rst_n = 1'b1;
    idle1();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.tick = 1'b0;    bus.keydown_start = 1'b0;    bus.keydown_confirm = 1'b0;
    bus.keydown_clear = 1'b0;    bus.keydown_num = 1'b0;    bus.num = 4'd0;
    bus_ar.tick = 1'b0; bus_ar.keydown_start = 1'b0; bus_ar.keydown_confirm = 1'b0;
    bus_ar.keydown_clear = 1'b0; bus_ar.keydown_num = 1'b0; bus_ar.num = 4'd0;
    @(negedge clk);
    test_reset();
    test_entry_confirm();
    test_countdown_alarm();
    test_entry_edges();
    test_pause_resume();
    test_auto_reload();
    test_clear_tick_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
